// File: rtl/proc_step_control.sv
// proc_step_control: T0..T3 step sequencer, instruction register and per-step strobe decode.
// Optional macro PROC_MVNZ_EN turns opcode 100 into mvnz Rx,Ry (conditional on G_nz).
`default_nettype none

module proc_step_control #(
   parameter int DIN_W = 9
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Run,
   input  logic [DIN_W-1:0] DIN,
   input  logic             G_nz,
   output logic             IRin,
   output logic [7:0]       Rin,
   output logic [7:0]       Rout,
   output logic             Ain,
   output logic             Gin,
   output logic             Gout,
   output logic             DINout,
   output logic             AddSub,
   output logic             Done,
   output logic [1:0]       Step
);

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_t;

   if (DIN_W < 9) begin : g_din_w_check
      $error("proc_step_control: DIN_W must be at least 9");
   end

   step_t      step_q, step_d;
   logic [8:0] ir_q, ir_d;

   logic [2:0] opcode;
   logic [7:0] x_oh;
   logic [7:0] y_oh;
   logic       is_arith;

   assign opcode   = ir_q[8:6];
   assign x_oh     = 8'd1 << ir_q[5:3];
   assign y_oh     = 8'd1 << ir_q[2:0];
   assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

   always_comb begin
      IRin   = 1'b0;
      Rin    = 8'd0;
      Rout   = 8'd0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DINout = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
      ir_d   = ir_q;
      step_d = step_q;

      // Reset holds every strobe low, including the Run-driven IRin.
      if (Resetn) begin
         case (step_q)
            T0: begin
               IRin = Run;
               if (Run) begin
                  ir_d = DIN[8:0];
               end
            end
            T1: begin
               case (opcode)
                  OP_MV: begin
                     Rout = y_oh;
                     Rin  = x_oh;
                     Done = 1'b1;
                  end
                  OP_MVI: begin
                     DINout = 1'b1;
                     Rin    = x_oh;
                     Done   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     Rout = x_oh;
                     Ain  = 1'b1;
                  end
                  OP_MVNZ: begin
`ifdef PROC_MVNZ_EN
                     if (G_nz) begin
                        Rout = y_oh;
                        Rin  = x_oh;
                     end
`endif
                     Done = 1'b1;
                  end
                  default: begin
                     Done = 1'b1;
                  end
               endcase
            end
            T2: begin
               if (is_arith) begin
                  Rout   = y_oh;
                  Gin    = 1'b1;
                  AddSub = (opcode == OP_SUB);
               end
            end
            T3: begin
               if (is_arith) begin
                  Gout = 1'b1;
                  Rin  = x_oh;
               end
               Done = 1'b1;
            end
         endcase
      end

      if (step_q == T0) begin
         step_d = Run ? T1 : T0;
      end else begin
         step_d = Done ? T0 : step_t'(step_q + 2'd1);
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step_q <= T0;
         ir_q   <= 9'd0;
      end else begin
         step_q <= step_d;
         ir_q   <= ir_d;
      end
   end

   assign Step = step_q;

`ifndef PROC_MVNZ_EN
   logic unused_g_nz;
   assign unused_g_nz = G_nz;
`endif

   if (DIN_W > 9) begin : g_din_wide
      logic unused_din_hi;
      assign unused_din_hi = ^DIN[DIN_W-1:9];
   end

   a_bus_exclusive: assert property (@(posedge Clock) disable iff (!Resetn)
      $onehot0({Rout, Gout, DINout}));

   a_rin_onehot: assert property (@(posedge Clock) disable iff (!Resetn)
      $onehot0(Rin));

endmodule

`default_nettype wire

// File: tb/tb_proc_step_control.sv
// tb_proc_step_control: randomized and directed checks of proc_step_control against a schedule model.
`default_nettype none

module tb_proc_step_control;

   logic       Clock = 1'b0;
   logic       Resetn;
   logic       Run;
   logic [8:0] DIN;
   logic       G_nz;
   logic       IRin, Ain, Gin, Gout, DINout, AddSub, Done;
   logic [7:0] Rin, Rout;
   logic [1:0] Step;

   int n_cmp = 0;
   int n_err = 0;

`ifdef PROC_MVNZ_EN
   localparam bit MVNZ = 1'b1;
`else
   localparam bit MVNZ = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] step;
      logic       irin;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       ain;
      logic       gin;
      logic       gout;
      logic       dinout;
      logic       addsub;
      logic       done;
   } vec_t;

   vec_t exp_q[$];
   vec_t obs_q[$];

   proc_step_control #(.DIN_W(9)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Run    (Run),
      .DIN    (DIN),
      .G_nz   (G_nz),
      .IRin   (IRin),
      .Rin    (Rin),
      .Rout   (Rout),
      .Ain    (Ain),
      .Gin    (Gin),
      .Gout   (Gout),
      .DINout (DINout),
      .AddSub (AddSub),
      .Done   (Done),
      .Step   (Step)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t obs_now();
      vec_t v;
      v.step   = Step;
      v.irin   = IRin;
      v.rin    = Rin;
      v.rout   = Rout;
      v.ain    = Ain;
      v.gin    = Gin;
      v.gout   = Gout;
      v.dinout = DINout;
      v.addsub = AddSub;
      v.done   = Done;
      return v;
   endfunction

   function automatic vec_t blank(input logic [1:0] s);
      vec_t v;
      v      = '0;
      v.step = s;
      return v;
   endfunction

   // Expected cycle-by-cycle schedule of one instruction, starting with its T0.
   function automatic void build_exp(input logic [8:0] instr, input logic gnz);
      logic [2:0] op = instr[8:6];
      int         x  = int'(instr[5:3]);
      int         y  = int'(instr[2:0]);
      vec_t       v;
      v = blank(2'd0);
      v.irin = 1'b1;
      exp_q.push_back(v);
      v = blank(2'd1);
      if (op == 3'd0) begin
         v.rout = 8'd1 << y; v.rin = 8'd1 << x; v.done = 1'b1;
         exp_q.push_back(v);
      end else if (op == 3'd1) begin
         v.dinout = 1'b1; v.rin = 8'd1 << x; v.done = 1'b1;
         exp_q.push_back(v);
      end else if (op == 3'd2 || op == 3'd3) begin
         v.rout = 8'd1 << x; v.ain = 1'b1;
         exp_q.push_back(v);
         v = blank(2'd2);
         v.rout = 8'd1 << y; v.gin = 1'b1; v.addsub = (op == 3'd3);
         exp_q.push_back(v);
         v = blank(2'd3);
         v.gout = 1'b1; v.rin = 8'd1 << x; v.done = 1'b1;
         exp_q.push_back(v);
      end else if (op == 3'd4 && MVNZ && gnz) begin
         v.rout = 8'd1 << y; v.rin = 8'd1 << x; v.done = 1'b1;
         exp_q.push_back(v);
      end else begin
         v.done = 1'b1;
         exp_q.push_back(v);
      end
   endfunction

   // Drives one instruction from T0 (entered at posedge+1) and records each cycle's outputs.
   task automatic drive_instr(input logic [8:0] instr, input logic [8:0] t1_din,
                              input logic gnz, input bit hold_run);
      logic d;
      Run  = 1'b1;
      DIN  = instr;
      G_nz = gnz;
      @(negedge Clock);
      obs_q.push_back(obs_now());
      @(posedge Clock); #1;
      for (int i = 0; i < 4; i++) begin
         DIN  = (i == 0) ? t1_din : 9'($urandom);
         Run  = hold_run ? 1'b1 : 1'($urandom);
         G_nz = gnz;
         @(negedge Clock);
         obs_q.push_back(obs_now());
         d = Done;
         @(posedge Clock); #1;
         if (d) break;
      end
      Run = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         Run  = 1'b0;
         DIN  = 9'($urandom);
         G_nz = 1'($urandom);
         exp_q.push_back(blank(2'd0));
         @(negedge Clock);
         obs_q.push_back(obs_now());
         @(posedge Clock); #1;
      end
   endtask

   task automatic test_reset();
      vec_t v;
      Resetn = 1'b1; Run = 1'b1; DIN = 9'h1ff; G_nz = 1'b1;
      #2 Resetn = 1'b0;
      #1 v = obs_now();
      n_cmp++;
      if (v !== blank(2'd0)) begin
         n_err++;
         $display("FAIL reset_initial: got %h expected %h", v, blank(2'd0));
      end
      @(posedge Clock); @(posedge Clock); #1;
      Resetn = 1'b1; Run = 1'b1; DIN = 9'b010_001_010;
      @(posedge Clock); #1;
      Run = 1'b0;
      @(posedge Clock); #1;
      n_cmp++;
      if (Step !== 2'd2 || Gin !== 1'b1) begin
         n_err++;
         $display("FAIL reset_pre_t2: got step=%0d gin=%b expected step=2 gin=1", Step, Gin);
      end
      #1 Resetn = 1'b0; Run = 1'b1;
      #1 v = obs_now();
      n_cmp++;
      if (v !== blank(2'd0)) begin
         n_err++;
         $display("FAIL reset_mid_add: got %h expected %h", v, blank(2'd0));
      end
      @(posedge Clock); #1;
      Resetn = 1'b1; Run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         v = obs_now();
         n_cmp++;
         if (v !== blank(2'd0)) begin
            n_err++;
            $display("FAIL reset_idle_%0d: got %h expected %h", i, v, blank(2'd0));
         end
         @(posedge Clock); #1;
      end
   endtask

   task automatic test_mvi();
      exp_q = {}; obs_q = {};
      build_exp(9'b001_011_000, 1'b0);
      drive_instr(9'b001_011_000, 9'd5, 1'b0, 1'b0);
      idle(1);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL mvi_len: got %0d cycles expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL mvi_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_add();
      exp_q = {}; obs_q = {};
      build_exp(9'b010_001_010, 1'b0);
      drive_instr(9'b010_001_010, 9'($urandom), 1'b0, 1'b0);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL add_len: got %0d cycles expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL add_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] sub_i, mv_i;
      exp_q = {}; obs_q = {};
      sub_i = {3'b011, 6'($urandom)};
      mv_i  = {3'b000, 6'($urandom)};
      build_exp(sub_i, 1'b0);
      build_exp(mv_i, 1'b0);
      drive_instr(sub_i, 9'($urandom), 1'b0, 1'b1);
      drive_instr(mv_i, 9'($urandom), 1'b0, 1'b1);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL b2b_len: got %0d cycles expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL b2b_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
         n_cmp++;
         if (!$onehot0({obs_q[i].rout, obs_q[i].gout, obs_q[i].dinout})) begin
            n_err++;
            $display("FAIL b2b_bus_excl%0d: got rout=%h gout=%b dinout=%b expected at most one driver",
                     i, obs_q[i].rout, obs_q[i].gout, obs_q[i].dinout);
         end
      end
   endtask

   task automatic test_nop();
      exp_q = {}; obs_q = {};
      build_exp(9'b111_000_000, 1'b0);
      drive_instr(9'b111_000_000, 9'($urandom), 1'b0, 1'b0);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL nop_len: got %0d cycles expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL nop_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_mvnz();
      exp_q = {}; obs_q = {};
      build_exp(9'b100_000_001, 1'b0);
      build_exp(9'b100_000_001, 1'b1);
      drive_instr(9'b100_000_001, 9'($urandom), 1'b0, 1'b0);
      drive_instr(9'b100_000_001, 9'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL mvnz_len: got %0d cycles expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL mvnz_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [8:0] instr;
      logic       g;
      exp_q = {}; obs_q = {};
      for (int n = 0; n < 60; n++) begin
         instr = 9'($urandom);
         g     = 1'($urandom);
         build_exp(instr, g);
         drive_instr(instr, 9'($urandom), g, 1'($urandom));
         idle(int'($urandom_range(0, 2)));
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL rand_len: got %0d cycles expected %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL rand_cyc%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mvi();
      test_add();
      test_back_to_back();
      test_nop();
      test_mvnz();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/proc_step_control.md
Name: proc_step_control

Overview:
- Control unit for the synchronous-execution simple processor.
- Owns a 2-bit time-step counter (T0..T3) and the 9-bit instruction register.
- Decodes each instruction into per-step datapath strobes: register load/drive enables, A/G enables, add/sub select and bus source.
- Sits between the instruction source (DIN/Run) and the register file, ALU and bus mux; it sequences them.

Parameters:
- DIN_W, 9, width of DIN. The instruction is always DIN[8:0]. Must be >= 9.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous active-low reset
- Run  in  1  start request; sampled only in T0
- DIN  in  DIN_W  instruction/data input; DIN[8:6]=opcode III, [5:3]=Rx XXX, [2:0]=Ry YYY
- G_nz  in  1  G register non-zero flag; used only with PROC_MVNZ_EN
- IRin  out  1  IR load strobe (mirrors internal IR load)
- Rin  out  8  one-hot register load enables R0..R7
- Rout  out  8  one-hot register bus-drive enables R0..R7
- Ain  out  1  A register load
- Gin  out  1  G register load
- Gout  out  1  G drives bus
- DINout  out  1  DIN drives bus
- AddSub  out  1  0=add, 1=subtract
- Done  out  1  instruction complete this cycle
- Step  out  2  current time step, for debug

Behaviour:
- Resetn low (async):
  - Step=0 and IR=9'b0 immediately.
  - All outputs forced to 0 while low, Run ignored.
  - Release is synchronous to the next Clock edge.
- Outputs are combinational from Step, the IR and Run (Moore-style plus Run in T0). Only Step and the IR are registered.
- Step counter:
  - On each edge, Step <= 0 if Done, else Step+1.
  - In T0 with Run=0, Step holds at 0.
  - Wrap 3->0 occurs only through Done; T3 always asserts Done.
- T0:
  - IRin=Run.
  - If Run=1, IR <= DIN[8:0] at the edge and Step -> 1. No other strobes.
- T1, by opcode:
  - 000 mv Rx,Ry: Rout[Y]=1, Rin[X]=1, Done=1.
  - 001 mvi Rx,#D: DINout=1, Rin[X]=1, Done=1. Immediate is read from DIN during T1.
  - 010 add / 011 sub: Rout[X]=1, Ain=1.
  - 101..111: NOP, Done=1, no strobes.
  - 100: see Optional Feature.
- T2, add/sub: Rout[Y]=1, Gin=1, AddSub=(opcode==011).
- T3, add/sub: Gout=1, Rin[X]=1, Done=1.
- Latency: mv/mvi/NOP take 2 cycles (T0,T1). add/sub take 4 cycles (T0..T3).
- Bus exclusivity: in every cycle, at most one of {any Rout bit, Gout, DINout} is 1.
- Rin and Rout are each one-hot or zero.
- X==Y is legal. For mv, Rout[X] and Rin[X] are both asserted.
- AddSub=0 in every step other than T2 of sub.
- Run is ignored outside T0. Its deassertion mid-instruction does not abort the instruction.
- Run held high: back-to-back instructions, with T0 immediately following the Done cycle.
- Reset mid-instruction aborts with no further strobes. The next instruction starts from T0.

Optional Feature:
- Macro PROC_MVNZ_EN.
- Defined: opcode 100 = mvnz Rx,Ry. In T1, if G_nz=1: Rout[Y]=1, Rin[X]=1, Done=1. If G_nz=0: Done=1 only.
- Undefined: opcode 100 is a NOP (Done in T1, no strobes) and G_nz is unused.

Test Plan:
- Reset: Resetn=0 mid-T2 of an add -> Step=0 and all outputs 0 without a clock edge. After release with Run=0, Step stays 0 for 5 cycles.
- mvi: Run=1, DIN=9'b001_011_000, then DIN=9'd5 in T1 -> T1 shows DINout=1, Rin=8'b00001000, Done=1. Next cycle Step=0.
- add: DIN=9'b010_001_010 -> T1: Rout=8'h02, Ain=1. T2: Rout=8'h04, Gin=1, AddSub=0. T3: Gout=1, Rin=8'h02, Done=1.
- sub then mv back-to-back with Run held high -> sub T2 has AddSub=1. The mv T0 immediately follows the sub T3, with IRin=1. The per-cycle bus-exclusivity assertion holds throughout.
- NOP: DIN=9'b111_000_000 -> T1: Done=1, Rin=0, Rout=0.
- PROC_MVNZ_EN: DIN=9'b100_000_001 with G_nz=0 -> T1: Done=1, Rin=0. Repeat with G_nz=1 -> Rout=8'h02, Rin=8'h01. Without the macro, both cases give Done only.
